// File: rtl/lpc_exc_if.sv
// -----------------------------------------------------------------------------
// lpc_exc_if
// Bundle of frame-parameter inputs and excitation outputs for
// lpc_excitation_gen.
//
// Handshake: there is no backpressure. d_clk is a one-cycle sample strobe and
// v is a one-cycle "new parameters" pulse; both are accepted on the cycle
// they are high. exc_vout is a one-cycle pulse marking exc_out valid, and
// frame_start pulses together with exc_vout on sample 0 of each frame.
//
// Signals (master = parameter source, slave = excitation generator):
//   d_clk, v, voiced, pulserate[15:0], lpcrate[15:0]   master -> slave
//   gain[15:0] (only with LPC_EXC_GAIN_EN)             master -> slave
//   exc_out[DW-1:0] (signed), exc_vout, frame_start,
//   underrun, state_dbg, pending_dbg                   slave -> master
// -----------------------------------------------------------------------------
interface lpc_exc_if #(
   parameter int DW = 16
);
   logic                 d_clk;
   logic                 v;
   logic                 voiced;
   logic [15:0]          pulserate;
   logic [15:0]          lpcrate;
`ifdef LPC_EXC_GAIN_EN
   logic [15:0]          gain;
`endif
   logic signed [DW-1:0] exc_out;
   logic                 exc_vout;
   logic                 frame_start;
   logic                 underrun;
   logic                 state_dbg;    // 0 = IDLE, 1 = RUN
   logic                 pending_dbg;  // shadow holds unapplied parameters

   modport master (
`ifdef LPC_EXC_GAIN_EN
      output gain,
`endif
      output d_clk, v, voiced, pulserate, lpcrate,
      input  exc_out, exc_vout, frame_start, underrun, state_dbg, pending_dbg
   );

   modport slave (
`ifdef LPC_EXC_GAIN_EN
      input  gain,
`endif
      input  d_clk, v, voiced, pulserate, lpcrate,
      output exc_out, exc_vout, frame_start, underrun, state_dbg, pending_dbg
   );
endinterface

// File: rtl/lpc_excitation_gen.sv
// -----------------------------------------------------------------------------
// lpc_excitation_gen
// Excitation source for an LPC synthesis filter. Emits one signed sample per
// d_clk strobe: a periodic pulse train for voiced frames, LFSR noise for
// unvoiced frames. Frame parameters (voiced, pulserate) are double-buffered
// in a shadow register and take effect only at frame boundaries.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - lpc_exc_if.slave: d_clk, v, voiced, pulserate, lpcrate (in);
//          exc_out, exc_vout, frame_start, underrun, state_dbg,
//          pending_dbg (out)
//
// Optional feature macro: LPC_EXC_GAIN_EN
//   Adds a Q2.14 unsigned gain input captured with v, applied at the frame
//   boundary, and a saturating multiply stage (output latency 2 instead of 1).
// -----------------------------------------------------------------------------
module lpc_excitation_gen #(
   parameter int          DW          = 16,
   parameter int          PULSE_AMP   = 8192,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int          NOISE_SHIFT = 2,
   parameter int          MIN_PITCH   = 20
) (
   input logic      clk,
   input logic      rst,
   lpc_exc_if.slave bus
);

   localparam logic [15:0]          LFSR_MASK = 16'hB400;
   localparam logic [15:0]          MIN_P     = 16'(MIN_PITCH);
   localparam logic signed [DW-1:0] PULSE     = DW'(PULSE_AMP);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic                 pending_q, pending_d;
   logic                 sh_voiced_q, sh_voiced_d;
   logic [15:0]          sh_rate_q, sh_rate_d;
   logic                 act_voiced_q, act_voiced_d;
   logic [15:0]          act_period_q, act_period_d;
   logic [15:0]          frame_len_q, frame_len_d;
   logic [15:0]          samp_cnt_q, samp_cnt_d;
   logic [15:0]          pitch_cnt_q, pitch_cnt_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic signed [DW-1:0] exc_out_q, exc_out_d;
   logic                 exc_vout_q, exc_vout_d;
   logic                 frame_start_q, frame_start_d;
   logic                 underrun_q, underrun_d;

`ifdef LPC_EXC_GAIN_EN
   localparam int PW = DW + 17;
   logic [15:0]          sh_gain_q, sh_gain_d;
   logic [15:0]          act_gain_q, act_gain_d;
   logic signed [DW-1:0] raw1_q, raw1_d;
   logic [15:0]          gain1_q, gain1_d;
   logic                 vld1_q, vld1_d;
   logic                 fs1_q, fs1_d;
   logic [15:0]          src_gain, cur_gain;
   logic signed [PW-1:0] a_ext, g_ext, prod, prod_sh, max_ext, min_ext;
   logic signed [DW-1:0] sat_out;
`endif

   // Event decode
   logic                 strobe, at_last, start_evt, boundary_evt, frame_evt;
   logic                 bypass, load_new, active_smp;
   logic                 src_voiced, eff_voiced, cur_voiced, force_phase;
   logic [15:0]          src_rate, eff_period, cur_period, pc_cur;
   logic                 lfsr_fb;
   logic signed [15:0]   noise16;
   logic signed [DW-1:0] raw;

   always_comb begin
      strobe       = bus.d_clk;
      at_last      = (samp_cnt_q == (frame_len_q - 16'd1));
      // In IDLE a v on the strobe cycle starts the frame directly, like a boundary.
      start_evt    = strobe && (state_q == S_IDLE) && (pending_q || bus.v);
      boundary_evt = strobe && (state_q == S_RUN) && at_last;
      frame_evt    = start_evt || boundary_evt;
      // A v coinciding with a frame start bypasses the shadow.
      bypass       = frame_evt && bus.v;
      load_new     = frame_evt && (bus.v || pending_q);
      active_smp   = (state_q == S_RUN) || start_evt;

      src_voiced   = bypass ? bus.voiced    : sh_voiced_q;
      src_rate     = bypass ? bus.pulserate : sh_rate_q;
      eff_voiced   = src_voiced && (src_rate != 16'd0);
      eff_period   = (src_rate < MIN_P) ? MIN_P : src_rate;

      cur_voiced   = load_new ? eff_voiced : act_voiced_q;
      cur_period   = load_new ? eff_period : act_period_q;
      // Phase restarts on a fresh voiced run; voiced->voiced carries the counter.
      force_phase  = start_evt || (load_new && eff_voiced && !act_voiced_q);
      pc_cur       = force_phase ? 16'd0 : pitch_cnt_q;

      // Feedback from bit 0 combined with bit 15 keeps the map invertible.
      lfsr_fb      = lfsr_q[0] ^ lfsr_q[15];
      noise16      = $signed(lfsr_q) >>> NOISE_SHIFT;
`ifdef LPC_EXC_GAIN_EN
      src_gain     = bypass ? bus.gain : sh_gain_q;
      cur_gain     = load_new ? src_gain : act_gain_q;
`endif
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (start_evt) state_d = S_RUN;
   end

   // Datapath next state
   always_comb begin
      pending_d    = pending_q;
      sh_voiced_d  = sh_voiced_q;
      sh_rate_d    = sh_rate_q;
      act_voiced_d = act_voiced_q;
      act_period_d = act_period_q;
      frame_len_d  = frame_len_q;
      samp_cnt_d   = samp_cnt_q;
      pitch_cnt_d  = pitch_cnt_q;
      lfsr_d       = lfsr_q;
      underrun_d   = underrun_q;
      raw          = '0;
`ifdef LPC_EXC_GAIN_EN
      sh_gain_d    = sh_gain_q;
      act_gain_d   = act_gain_q;
`endif

      if (bus.v && !bypass) begin
         sh_voiced_d = bus.voiced;
         sh_rate_d   = bus.pulserate;
         pending_d   = 1'b1;
`ifdef LPC_EXC_GAIN_EN
         sh_gain_d   = bus.gain;
`endif
      end

      if (frame_evt) pending_d = 1'b0;

      if (load_new) begin
         act_voiced_d = eff_voiced;
         act_period_d = eff_period;
`ifdef LPC_EXC_GAIN_EN
         act_gain_d   = src_gain;
`endif
      end

      if (boundary_evt && !load_new) underrun_d = 1'b1;

      if (frame_evt) begin
         frame_len_d = (bus.lpcrate < 16'd2) ? 16'd2 : bus.lpcrate;
         samp_cnt_d  = '0;
      end else if (strobe && (state_q == S_RUN)) begin
         samp_cnt_d  = samp_cnt_q + 16'd1;
      end

      if (strobe) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_fb ? LFSR_MASK : 16'h0000);
         if (active_smp) begin
            if (cur_voiced) begin
               if (pc_cur == 16'd0) begin
                  raw         = PULSE;
                  pitch_cnt_d = cur_period - 16'd1;
               end else begin
                  raw         = '0;
                  pitch_cnt_d = pc_cur - 16'd1;
               end
            end else begin
               raw = DW'(noise16);
            end
         end
      end
   end

`ifdef LPC_EXC_GAIN_EN
   // Q2.14 gain multiply with saturation to DW bits.
   always_comb begin
      a_ext   = {{17{raw1_q[DW-1]}}, raw1_q};
      g_ext   = {{(DW+1){1'b0}}, gain1_q};
      prod    = a_ext * g_ext;
      prod_sh = prod >>> 14;
      max_ext = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
      min_ext = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
      if (prod_sh > max_ext)      sat_out = max_ext[DW-1:0];
      else if (prod_sh < min_ext) sat_out = min_ext[DW-1:0];
      else                        sat_out = prod_sh[DW-1:0];
   end
`endif

   // FSM: outputs
   always_comb begin
      exc_out_d     = exc_out_q;
      exc_vout_d    = 1'b0;
      frame_start_d = 1'b0;
`ifdef LPC_EXC_GAIN_EN
      raw1_d  = raw1_q;
      gain1_d = gain1_q;
      vld1_d  = strobe;
      fs1_d   = strobe && frame_evt;
      if (strobe) begin
         raw1_d  = raw;
         gain1_d = cur_gain;
      end
      if (vld1_q) begin
         exc_out_d     = sat_out;
         exc_vout_d    = 1'b1;
         frame_start_d = fs1_q;
      end
`else
      if (strobe) begin
         exc_out_d     = raw;
         exc_vout_d    = 1'b1;
         frame_start_d = frame_evt;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q     <= 1'b0;
         sh_voiced_q   <= 1'b0;
         sh_rate_q     <= '0;
         act_voiced_q  <= 1'b0;
         act_period_q  <= '0;
         frame_len_q   <= '0;
         samp_cnt_q    <= '0;
         pitch_cnt_q   <= '0;
         lfsr_q        <= LFSR_SEED;
         exc_out_q     <= '0;
         exc_vout_q    <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
`ifdef LPC_EXC_GAIN_EN
         sh_gain_q     <= '0;
         act_gain_q    <= '0;
         raw1_q        <= '0;
         gain1_q       <= '0;
         vld1_q        <= 1'b0;
         fs1_q         <= 1'b0;
`endif
      end else begin
         pending_q     <= pending_d;
         sh_voiced_q   <= sh_voiced_d;
         sh_rate_q     <= sh_rate_d;
         act_voiced_q  <= act_voiced_d;
         act_period_q  <= act_period_d;
         frame_len_q   <= frame_len_d;
         samp_cnt_q    <= samp_cnt_d;
         pitch_cnt_q   <= pitch_cnt_d;
         lfsr_q        <= lfsr_d;
         exc_out_q     <= exc_out_d;
         exc_vout_q    <= exc_vout_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
`ifdef LPC_EXC_GAIN_EN
         sh_gain_q     <= sh_gain_d;
         act_gain_q    <= act_gain_d;
         raw1_q        <= raw1_d;
         gain1_q       <= gain1_d;
         vld1_q        <= vld1_d;
         fs1_q         <= fs1_d;
`endif
      end
   end

   assign bus.exc_out     = exc_out_q;
   assign bus.exc_vout    = exc_vout_q;
   assign bus.frame_start = frame_start_q;
   assign bus.underrun    = underrun_q;
   assign bus.state_dbg   = state_q;
   assign bus.pending_dbg = pending_q;

endmodule

// File: tb/tb_lpc_excitation_gen.sv
// -----------------------------------------------------------------------------
// tb_lpc_excitation_gen
// Directed testbench for lpc_excitation_gen (default build, latency 1).
// Inputs change on the falling edge; outputs are read on the following
// falling edge, half a cycle after the registering rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lpc_excitation_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lpc_exc_if #(.DW(16)) bus();

   lpc_excitation_gen #(.DW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef LPC_EXC_GAIN_EN
   initial bus.gain = 16'h4000;
`endif

   int                 n_checks = 0;
   int                 n_fail   = 0;
   logic [15:0]        lfsr_m;    // bench noise-generator model
   logic [15:0]        lfsr_at;   // model value used by the last strobe
   logic signed [15:0] got_out;
   logic               got_vout, got_fs, got_ur, got_st;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[15];
      return (s >> 1) ^ (fb ? 16'hB400 : 16'h0000);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.d_clk = 1'b0; bus.v = 1'b0; bus.voiced = 1'b0;
      bus.pulserate = '0; bus.lpcrate = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      lfsr_m = 16'hACE1;
   endtask

   task automatic send_v(input logic vc, input logic [15:0] pr);
      bus.v = 1'b1; bus.voiced = vc; bus.pulserate = pr;
      @(negedge clk);
      bus.v = 1'b0;
   endtask

   // One strobe, sample outputs, then one idle cycle.
   task automatic do_strobe(input logic with_v);
      bus.d_clk = 1'b1; bus.v = with_v;
      @(negedge clk);
      bus.d_clk = 1'b0; bus.v = 1'b0;
      got_out = bus.exc_out; got_vout = bus.exc_vout; got_fs = bus.frame_start;
      got_ur = bus.underrun; got_st = bus.state_dbg;
      lfsr_at = lfsr_m;
      lfsr_m = lfsr_step(lfsr_m);
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (bus.exc_out !== 16'sd0) begin n_fail++; $display("FAIL rst_out got %0d want 0", bus.exc_out); end
      n_checks++; if (bus.exc_vout !== 1'b0) begin n_fail++; $display("FAIL rst_vout got %b want 0", bus.exc_vout); end
      n_checks++; if (bus.underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun got %b want 0", bus.underrun); end
      n_checks++; if (bus.state_dbg !== 1'b0) begin n_fail++; $display("FAIL rst_state got %b want 0", bus.state_dbg); end
      for (int i = 0; i < 5; i++) begin
         do_strobe(1'b0);
         n_checks++; if (got_vout !== 1'b1) begin n_fail++; $display("FAIL idle_vout[%0d] got %b want 1", i, got_vout); end
         n_checks++; if (got_out !== 16'sd0) begin n_fail++; $display("FAIL idle_out[%0d] got %0d want 0", i, got_out); end
         n_checks++; if (got_ur !== 1'b0) begin n_fail++; $display("FAIL idle_underrun[%0d] got %b want 0", i, got_ur); end
      end
      n_checks++; if (bus.exc_vout !== 1'b0) begin n_fail++; $display("FAIL gap_vout got %b want 0", bus.exc_vout); end
   endtask

   task automatic test_voiced_pitch();
      logic signed [15:0] exp;
      do_reset();
      bus.lpcrate = 16'd240;
      send_v(1'b1, 16'd40);
      for (int i = 0; i < 240; i++) begin
         do_strobe(1'b0);
         exp = (i % 40 == 0) ? 16'sd8192 : 16'sd0;
         n_checks++; if (got_out !== exp) begin n_fail++; $display("FAIL pitch_out[%0d] got %0d want %0d", i, got_out, exp); end
         n_checks++; if (got_fs !== (i == 0)) begin n_fail++; $display("FAIL pitch_fs[%0d] got %b want %b", i, got_fs, (i == 0)); end
      end
      n_checks++; if (got_st !== 1'b1) begin n_fail++; $display("FAIL pitch_state got %b want 1", got_st); end
   endtask

   task automatic test_unvoiced_lfsr();
      logic signed [15:0] exp_tab [4];
      exp_tab[0] = 16'shEB38; exp_tab[1] = 16'sh159C;
      exp_tab[2] = 16'sh0ACE; exp_tab[3] = 16'sh0567;
      do_reset();
      bus.lpcrate = 16'd240;
      send_v(1'b0, 16'd40);
      for (int i = 0; i < 4; i++) begin
         do_strobe(1'b0);
         n_checks++; if (got_out !== exp_tab[i]) begin n_fail++; $display("FAIL noise_out[%0d] got %h want %h", i, got_out, exp_tab[i]); end
      end
   endtask

   task automatic test_underrun();
      logic signed [15:0] exp;
      do_reset();
      bus.lpcrate = 16'd10;
      send_v(1'b1, 16'd40);
      for (int i = 0; i < 45; i++) begin
         do_strobe(1'b0);
         exp = (i % 40 == 0) ? 16'sd8192 : 16'sd0;
         n_checks++; if (got_out !== exp) begin n_fail++; $display("FAIL ur_out[%0d] got %0d want %0d", i, got_out, exp); end
         n_checks++; if (got_ur !== (i >= 10)) begin n_fail++; $display("FAIL ur_flag[%0d] got %b want %b", i, got_ur, (i >= 10)); end
         n_checks++; if (got_fs !== (i % 10 == 0)) begin n_fail++; $display("FAIL ur_fs[%0d] got %b want %b", i, got_fs, (i % 10 == 0)); end
      end
   endtask

   task automatic test_boundary_bypass();
      logic signed [15:0] exp;
      do_reset();
      bus.lpcrate = 16'd10;
      send_v(1'b1, 16'd40);
      for (int i = 0; i <= 20; i++) begin
         if (i == 10) begin
            bus.voiced = 1'b0; bus.pulserate = 16'd40;
            do_strobe(1'b1);
         end else begin
            do_strobe(1'b0);
         end
         if (i < 10) exp = (i == 0) ? 16'sd8192 : 16'sd0;
         else        exp = $signed(lfsr_at) >>> 2;
         n_checks++; if (got_out !== exp) begin n_fail++; $display("FAIL byp_out[%0d] got %0d want %0d", i, got_out, exp); end
         n_checks++; if (got_ur !== (i >= 20)) begin n_fail++; $display("FAIL byp_underrun[%0d] got %b want %b", i, got_ur, (i >= 20)); end
         n_checks++; if (got_fs !== (i % 10 == 0)) begin n_fail++; $display("FAIL byp_fs[%0d] got %b want %b", i, got_fs, (i % 10 == 0)); end
      end
   endtask

   task automatic test_clamp();
      logic signed [15:0] exp;
      do_reset();
      bus.lpcrate = 16'd100;
      send_v(1'b1, 16'd5);
      for (int i = 0; i < 60; i++) begin
         do_strobe(1'b0);
         exp = (i % 20 == 0) ? 16'sd8192 : 16'sd0;
         n_checks++; if (got_out !== exp) begin n_fail++; $display("FAIL clamp_out[%0d] got %0d want %0d", i, got_out, exp); end
      end
      // pulserate 0 turns a voiced frame into noise
      do_reset();
      bus.lpcrate = 16'd100;
      send_v(1'b1, 16'd0);
      for (int i = 0; i < 3; i++) begin
         do_strobe(1'b0);
         exp = $signed(lfsr_at) >>> 2;
         n_checks++; if (got_out !== exp) begin n_fail++; $display("FAIL zero_rate_out[%0d] got %0d want %0d", i, got_out, exp); end
      end
      // lpcrate 1 is raised to a 2-sample frame
      do_reset();
      bus.lpcrate = 16'd1;
      send_v(1'b1, 16'd40);
      for (int i = 0; i < 6; i++) begin
         do_strobe(1'b0);
         n_checks++; if (got_fs !== (i % 2 == 0)) begin n_fail++; $display("FAIL minlen_fs[%0d] got %b want %b", i, got_fs, (i % 2 == 0)); end
      end
   endtask

   task automatic test_phase();
      logic signed [15:0] exp;
      do_reset();
      bus.lpcrate = 16'd240;
      send_v(1'b1, 16'd40);
      for (int i = 0; i < 400; i++) begin
         do_strobe(1'b0);
         if (i == 100) send_v(1'b1, 16'd50);
         if (i < 240) exp = (i % 40 == 0) ? 16'sd8192 : 16'sd0;
         else         exp = ((i - 240) % 50 == 0) ? 16'sd8192 : 16'sd0;
         n_checks++; if (got_out !== exp) begin n_fail++; $display("FAIL phase_out[%0d] got %0d want %0d", i, got_out, exp); end
      end
      n_checks++; if (got_ur !== 1'b0) begin n_fail++; $display("FAIL phase_underrun got %b want 0", got_ur); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.lpcrate = 16'd240;
      send_v(1'b1, 16'd50);
      for (int i = 0; i <= 100; i++) begin
         do_strobe(1'b0);
         if (i == 60) send_v(1'b0, 16'd30);
      end
      n_checks++; if (got_out !== 16'sd8192) begin n_fail++; $display("FAIL mid_pre_out got %0d want 8192", got_out); end
      n_checks++; if (bus.pending_dbg !== 1'b1) begin n_fail++; $display("FAIL mid_pre_pending got %b want 1", bus.pending_dbg); end
      rst = 1'b1;
      #1;
      n_checks++; if (bus.exc_out !== 16'sd0) begin n_fail++; $display("FAIL mid_out got %0d want 0", bus.exc_out); end
      n_checks++; if (bus.state_dbg !== 1'b0) begin n_fail++; $display("FAIL mid_state got %b want 0", bus.state_dbg); end
      n_checks++; if (bus.pending_dbg !== 1'b0) begin n_fail++; $display("FAIL mid_pending got %b want 0", bus.pending_dbg); end
      @(negedge clk);
      rst = 1'b0;
      lfsr_m = 16'hACE1;
      for (int i = 0; i < 3; i++) begin
         do_strobe(1'b0);
         n_checks++; if (got_out !== 16'sd0) begin n_fail++; $display("FAIL post_out[%0d] got %0d want 0", i, got_out); end
         n_checks++; if (got_fs !== 1'b0) begin n_fail++; $display("FAIL post_fs[%0d] got %b want 0", i, got_fs); end
         n_checks++; if (got_st !== 1'b0) begin n_fail++; $display("FAIL post_state[%0d] got %b want 0", i, got_st); end
      end
   endtask

   initial begin
      bus.d_clk = 1'b0; bus.v = 1'b0; bus.voiced = 1'b0;
      bus.pulserate = '0; bus.lpcrate = '0;
      lfsr_m = 16'hACE1; lfsr_at = 16'hACE1;
      test_reset();
      test_voiced_pitch();
      test_unvoiced_lfsr();
      test_underrun();
      test_boundary_bypass();
      test_clamp();
      test_phase();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lpc_excitation_gen.md
Name: lpc_excitation_gen

Overview:
- First stage of the LPC decode path; produces the excitation signal that drives the all-pole synthesis filter.
- Consumes the frame parameters from the LPC encoder: v, voiced and pulserate (the pitch period).
- Emits one signed excitation sample per d_clk strobe:
  - voiced frames: a periodic pulse train;
  - unvoiced frames: LFSR white noise.
- Frame parameters are double-buffered and take effect only at frame boundaries, every lpcrate samples.

Parameters:
- DW, 16, excitation sample width (signed).
- PULSE_AMP, 8192, signed amplitude of a voiced pulse.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- NOISE_SHIFT, 2, arithmetic right shift applied to LFSR output for noise level.
- MIN_PITCH, 20, lower clamp on pulserate, in samples.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- d_clk  in  1  sample strobe in the clk domain; one-cycle pulse per sample.
- v  in  1  one-cycle pulse: new frame parameters valid.
- voiced  in  1  frame is voiced; sampled when v=1.
- pulserate  in  16  pitch period in samples; sampled when v=1.
- lpcrate  in  16  frame length in samples; sampled at every frame boundary.
- exc_out  out  DW  signed excitation sample, registered.
- exc_vout  out  1  one-cycle pulse: exc_out valid.
- frame_start  out  1  one-cycle pulse together with exc_vout on the first sample of each frame.
- underrun  out  1  sticky flag: a frame boundary was reached with no new parameters pending.

Behaviour:
- Reset (async, rst=1) values:
  - exc_out=0, exc_vout=0, frame_start=0, underrun=0;
  - state=IDLE, shadow and active registers=0;
  - LFSR=LFSR_SEED, sample and pitch counters=0.
- Shadow capture: on v=1, voiced and pulserate are written into the shadow register and pending is set. A later v before the boundary overwrites the shadow; the last write wins.
- Clamping: effective period = max(pulserate, MIN_PITCH). pulserate=0 forces the frame to unvoiced.
- Frame length: frame length = max(lpcrate, 2), sampled at each frame boundary.
- State IDLE:
  - d_clk strobes produce exc_out=0 with exc_vout=1.
  - On the first strobe with pending=1: load active from shadow, clear pending, enter RUN. That strobe is sample 0 of the frame (frame_start=1).
- State RUN:
  - Each d_clk strobe advances the sample counter.
  - At count = frame length-1, the next strobe is a boundary.
  - Boundary with pending=1: load shadow into active, clear pending.
  - Boundary with pending=0: keep active and set underrun (sticky until rst).
- Simultaneous events:
  - v=1 on the same cycle as a boundary strobe: the new values bypass the shadow, apply to that frame immediately, and pending stays 0.
  - v=1 on a non-strobe cycle: captured normally.
- Voiced frames:
  - The pitch counter decrements per strobe. At 0 the block emits PULSE_AMP and reloads to effective period-1; otherwise it emits 0.
  - The counter carries across voiced→voiced boundaries, so pitch phase is continuous.
  - On an unvoiced→voiced or IDLE→RUN transition the counter is forced to 0, so a pulse occurs on the frame's first sample.
- Unvoiced frames: exc_out = LFSR >>> NOISE_SHIFT (signed arithmetic shift).
- LFSR: 16-bit Galois, mask 16'hB400, shift right. It advances on every d_clk strobe in every state, so the noise sequence is independent of voicing.
- Latency: exc_out, exc_vout and frame_start are registered one cycle after the d_clk strobe. There is no backpressure, and a strobe is never dropped.
- Non-strobe cycles: exc_vout=0 and exc_out holds its last value.
- Reset mid-frame: all state is discarded immediately, including pending parameters, and the block returns to IDLE.

Optional Feature:
- Macro LPC_EXC_GAIN_EN.
- Defined:
  - adds input port gain [15:0], unsigned Q2.14, captured with v into the shadow and applied at the boundary like the other parameters;
  - exc_out = saturate_DW((raw × gain) >>> 14);
  - this adds one pipeline register, so latency becomes 2 cycles after d_clk.
- Undefined: no gain port, unity gain, latency 1 cycle.

Test Plan:
- Reset and idle: rst pulse, then 5 d_clk strobes with no v → exc_vout 5 times, exc_out=0, underrun=0.
- Voiced pitch:
  - Stimulus: v with voiced=1, pulserate=40, lpcrate=240, then 240 strobes.
  - Required: pulses of 8192 at samples 0, 40, …, 200 (6 pulses), all other samples 0, frame_start on sample 0 only.
- Unvoiced LFSR:
  - Stimulus: rst, then v with voiced=0, then 4 strobes.
  - Required: exc_out = the LFSR values 16'hACE1, 16'h5670, 16'h2B38, 16'h159C each shifted >>> 2, in order, with the LFSR advancing on every strobe.
- Boundary and underrun:
  - lpcrate=10 with no second v → underrun rises on strobe 10 and the voiced pattern continues unchanged.
  - Same setup with v on the strobe-10 cycle: the new parameters apply on sample 10 and underrun stays 0.
- Clamp and phase:
  - pulserate=5 → the period used is 20.
  - voiced(40) frame followed by a voiced(50) frame → the first pulse of frame 2 arrives 40 samples after the last pulse of frame 1; the following pulses are spaced 50.
- Reset mid-frame: assert rst at sample 100 of a voiced frame → outputs are 0 immediately, the block is in IDLE, and the pending shadow is cleared.
